alu_sequencer: RTL and testbench
================================

# alu_sequencer

Hardwired control unit for the Mini-SRC phase-1 datapath. Steps the datapath through instruction fetch (T0–T2) and execute (T3–T6) for register ALU, multiply/divide, unary, nop and halt instructions. It drives every datapath enable that testbenches previously hand-sequenced, and decodes register fields from IR. It sits beside `datapath`: IR feeds in, one-hot register selects and unit enables feed out.

## Interface
- No parameters.
- clock  in  1  system clock; all state changes on rising edge.
- clear  in  1  reset, asynchronous, active-high.
- IR  in  32  datapath instruction register contents.
- mem_ready  in  1  memory data valid on Mdatain this cycle.
- stop  in  1  request to halt at the next instruction boundary.
- Rin  out  16  one-hot register write enables; bit n drives Rnin.
- Rout  out  16  one-hot register bus drives; bit n drives Rnout.
- HIin, LOin, PCin, MDRin, IRin, MARin, Yin, Zin  out  1 each  datapath load enables.
- HIout, LOout, Zhighout, Zlowout, PCout, MDRout  out  1 each  bus drive enables.
- Read  out  1  MDR source select = memory.
- IncPC  out  1  ALU computes PC+1.
- ALU_Control  out  5  ALU operation code.
- run  out  1  high while sequencing; low in RESET and HALT.
- instr_done  out  1  high during the final execute step of each instruction.
- Zhighin, Zlowin, In_Portin, In_Portout, Coutin, Coutout are not driven here; the top level ties them low.

## Operation
- IR fields: op = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
- Opcode classes:
  - R3: 0x00 add, 0x01 sub, 0x02 and, 0x03 or, 0x04 shr, 0x05 shra, 0x06 shl, 0x07 ror, 0x08 rol.
  - MD: 0x0F mul, 0x10 div.
  - UN: 0x11 neg, 0x12 not.
  - 0x1B halt.
  - Every other opcode, including 0x1A, is a nop.
- Outputs are a Moore decode of the state register plus the registered IR. Every output not listed for a state is 0.
- States: RESET, T0–T6, HALT.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin; ALU_Control = 0x00.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Execute, by class:
  - R3:
    - T3: Rout[Rb], Yin.
    - T4: Rout[Rc], Zin, ALU_Control = op.
    - T5: Zlowout, Rin[Ra], instr_done.
  - MD:
    - T3: Rout[Ra], Yin.
    - T4: Rout[Rb], Zin, ALU_Control = op.
    - T5: Zlowout, LOin.
    - T6: Zhighout, HIin, instr_done.
  - UN:
    - T3: Rout[Rb], Zin, ALU_Control = op.
    - T4: Zlowout, Rin[Ra], instr_done.
  - nop: T3 with instr_done only.
  - halt: T3 with instr_done only; next state is HALT.
- Transitions:
  - RESET → T0.
  - T0 → T1.
  - T1 → T2 only when mem_ready = 1; otherwise T1 holds with its outputs (PCin included) held.
  - T2 → T3, then each step advances to the next until the instr_done state.
  - From the instr_done state: HALT if op = halt or stop = 1 in that cycle; otherwise T0.
  - HALT holds until clear.
- ALU_Control = op is always the raw 5-bit opcode. Register indices are 4-bit; all 16 are valid, including R0 as destination.

## Timing
- While clear = 1: state = RESET and all outputs = 0, asynchronously, including mid-instruction. No partial register write completes after clear asserts.
- The first rising edge after clear falls enters T0.
- Enables are valid for the whole state. The datapath latches on the rising edge that ends the state.
- Latency per instruction, with mem_ready = 1 in T1:
  - R3: 6 cycles.
  - MD: 7 cycles.
  - UN: 5 cycles.
  - nop and halt: 4 cycles.
- Each cycle of mem_ready = 0 in T1 adds one cycle.
- stop is sampled only in the instr_done state. Asserted elsewhere it has no effect unless still high at that point.
- Rout and Rin are never both nonzero. At most one bus driver is active in any state.

## Test plan
- Reset: clear = 1 at t = 0, released at 5 ns → run = 0 and all outputs 0 during reset; state T0 after the first edge; PCout = MARin = IncPC = Zin = 1.
- ror R7,R0,R4 (IR = 0x3B820000, R0 = 0x34, R4 = 0x45, mem_ready = 1):
  - T3 Rout = 0x0001, Yin.
  - T4 Rout = 0x0010, ALU_Control = 0x07.
  - T5 Rin = 0x0080, instr_done.
  - R7 = ror(0x34, 5) = 0xA0000001.
  - Next instruction's T0 follows 6 cycles after T0.
- mul R2,R3 (IR = 0x79180000) → T5 Zlowout + LOin; T6 Zhighout + HIin + instr_done; 7-cycle instruction.
- Memory stall: mem_ready = 0 for 3 cycles in T1 → T1 held 4 cycles with Read/MDRin/PCin steady; T2 on the cycle after mem_ready rises.
- halt (IR = 0xD8000000) → T3 instr_done, then HALT: run = 0, all outputs 0, held for 10+ cycles. stop = 1 during an add's T4 → HALT after that add's T5.
- Mid-instruction reset: clear pulse during T4 of an R3 op → outputs 0 immediately; Ra is not written; restarts at T0.

Source files
------------

// File: rtl/alu_sequencer.sv
// Hardwired fetch/execute control unit for the Mini-SRC phase-1 datapath.
// Outputs are a Moore decode of the step register and the instruction held in IR.
module alu_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  input  logic        stop,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        HIin,
  output logic        LOin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        MARin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIout,
  output logic        LOout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        PCout,
  output logic        MDRout,
  output logic        Read,
  output logic        IncPC,
  output logic [4:0]  ALU_Control,
  output logic        run,
  output logic        instr_done
);

  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_HALT  = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    CL_R3   = 3'd0,
    CL_MD   = 3'd1,
    CL_UN   = 3'd2,
    CL_NOP  = 3'd3,
    CL_HALT = 3'd4
  } class_t;

  function automatic class_t decode_class(input logic [4:0] op);
    case (op)
      5'h00, 5'h01, 5'h02, 5'h03, 5'h04,
      5'h05, 5'h06, 5'h07, 5'h08: decode_class = CL_R3;
      5'h0F, 5'h10:               decode_class = CL_MD;
      5'h11, 5'h12:               decode_class = CL_UN;
      5'h1B:                      decode_class = CL_HALT;
      default:                    decode_class = CL_NOP;
    endcase
  endfunction

  function automatic logic [15:0] one_hot16(input logic [3:0] idx);
    one_hot16 = 16'h0001 << idx;
  endfunction

  state_t      state_r;
  state_t      state_next_s;
  class_t      class_s;
  logic [4:0]  op_s;
  logic [3:0]  ra_s;
  logic [3:0]  rb_s;
  logic [3:0]  rc_s;
  logic        done_s;
  logic        ir_unused_s;

  assign op_s    = IR[31:27];
  assign ra_s    = IR[26:23];
  assign rb_s    = IR[22:19];
  assign rc_s    = IR[18:15];
  assign class_s = decode_class(op_s);
  // Low IR bits carry immediates that this phase never consumes.
  assign ir_unused_s = ^IR[14:0];

  // Final execute step for the current instruction class.
  always_comb begin
    done_s = 1'b0;
    case (state_r)
      ST_T3:   done_s = (class_s == CL_NOP) || (class_s == CL_HALT);
      ST_T4:   done_s = (class_s == CL_UN);
      ST_T5:   done_s = (class_s == CL_R3);
      ST_T6:   done_s = (class_s == CL_MD);
      default: done_s = 1'b0;
    endcase
  end

  // Step sequencing; T1 waits on memory, the done step picks HALT or T0.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RESET: state_next_s = ST_T0;
      ST_T0:    state_next_s = ST_T1;
      ST_T1: begin
        if (mem_ready) state_next_s = ST_T2;
        else           state_next_s = ST_T1;
      end
      ST_T2:    state_next_s = ST_T3;
      ST_T3, ST_T4, ST_T5, ST_T6: begin
        if (done_s) begin
          if ((class_s == CL_HALT) || stop) state_next_s = ST_HALT;
          else                              state_next_s = ST_T0;
        end else if (state_r == ST_T3) begin
          state_next_s = ST_T4;
        end else if (state_r == ST_T4) begin
          state_next_s = ST_T5;
        end else if (state_r == ST_T5) begin
          state_next_s = ST_T6;
        end else begin
          state_next_s = ST_T0;
        end
      end
      ST_HALT:  state_next_s = ST_HALT;
      default:  state_next_s = ST_RESET;
    endcase
  end

  // Step register; clear forces RESET immediately so every enable drops at once.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_r <= ST_RESET;
    else       state_r <= state_next_s;
  end

  // Moore output decode.
  always_comb begin
    Rin         = 16'h0000;
    Rout        = 16'h0000;
    HIin        = 1'b0;
    LOin        = 1'b0;
    PCin        = 1'b0;
    MDRin       = 1'b0;
    IRin        = 1'b0;
    MARin       = 1'b0;
    Yin         = 1'b0;
    Zin         = 1'b0;
    HIout       = 1'b0;
    LOout       = 1'b0;
    Zhighout    = 1'b0;
    Zlowout     = 1'b0;
    PCout       = 1'b0;
    MDRout      = 1'b0;
    Read        = 1'b0;
    IncPC       = 1'b0;
    ALU_Control = 5'h00;
    instr_done  = done_s;
    if ((state_r == ST_RESET) || (state_r == ST_HALT)) run = 1'b0;
    else                                               run = 1'b1;
    case (state_r)
      ST_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        case (class_s)
          CL_R3:   begin Rout = one_hot16(rb_s); Yin = 1'b1; end
          CL_MD:   begin Rout = one_hot16(ra_s); Yin = 1'b1; end
          CL_UN:   begin Rout = one_hot16(rb_s); Zin = 1'b1; ALU_Control = op_s; end
          default: Rout = 16'h0000;
        endcase
      end
      ST_T4: begin
        case (class_s)
          CL_R3:   begin Rout = one_hot16(rc_s); Zin = 1'b1; ALU_Control = op_s; end
          CL_MD:   begin Rout = one_hot16(rb_s); Zin = 1'b1; ALU_Control = op_s; end
          CL_UN:   begin Zlowout = 1'b1; Rin = one_hot16(ra_s); end
          default: Rout = 16'h0000;
        endcase
      end
      ST_T5: begin
        case (class_s)
          CL_R3:   begin Zlowout = 1'b1; Rin = one_hot16(ra_s); end
          CL_MD:   begin Zlowout = 1'b1; LOin = 1'b1; end
          default: Rin = 16'h0000;
        endcase
      end
      ST_T6: begin
        if (class_s == CL_MD) begin
          Zhighout = 1'b1;
          HIin     = 1'b1;
        end else begin
          Zhighout = 1'b0;
        end
      end
      default: Rin = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a tiny bus/register model standing in for the datapath.
module tb_alu_sequencer;

  logic        clock = 1'b1;
  logic        clear = 1'b1;
  logic [31:0] IR = 32'h0;
  logic        mem_ready = 1'b1;
  logic        stop = 1'b0;
  logic [15:0] Rin, Rout;
  logic        HIin, LOin, PCin, MDRin, IRin, MARin, Yin, Zin;
  logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Read, IncPC;
  logic [4:0]  ALU_Control;
  logic        run, instr_done;

  int n_vec = 0;
  int n_err = 0;

  alu_sequencer dut (
    .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready), .stop(stop),
    .Rin(Rin), .Rout(Rout), .HIin(HIin), .LOin(LOin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .MARin(MARin), .Yin(Yin), .Zin(Zin), .HIout(HIout), .LOout(LOout),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .PCout(PCout), .MDRout(MDRout),
    .Read(Read), .IncPC(IncPC), .ALU_Control(ALU_Control), .run(run),
    .instr_done(instr_done)
  );

  always #5 clock = ~clock;

  localparam logic [17:0] M_RUN   = 18'h00001;
  localparam logic [17:0] M_DONE  = 18'h00002;
  localparam logic [17:0] M_INCPC = 18'h00004;
  localparam logic [17:0] M_READ  = 18'h00008;
  localparam logic [17:0] M_MDROUT= 18'h00010;
  localparam logic [17:0] M_PCOUT = 18'h00020;
  localparam logic [17:0] M_ZLOUT = 18'h00040;
  localparam logic [17:0] M_ZHOUT = 18'h00080;
  localparam logic [17:0] M_ZIN   = 18'h00400;
  localparam logic [17:0] M_YIN   = 18'h00800;
  localparam logic [17:0] M_MARIN = 18'h01000;
  localparam logic [17:0] M_IRIN  = 18'h02000;
  localparam logic [17:0] M_MDRIN = 18'h04000;
  localparam logic [17:0] M_PCIN  = 18'h08000;
  localparam logic [17:0] M_LOIN  = 18'h10000;
  localparam logic [17:0] M_HIIN  = 18'h20000;

  localparam logic [54:0] F_T0 = {M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN, 16'h0, 16'h0, 5'h00};
  localparam logic [54:0] F_T1 = {M_ZLOUT | M_PCIN | M_READ | M_MDRIN | M_RUN, 16'h0, 16'h0, 5'h00};
  localparam logic [54:0] F_T2 = {M_MDROUT | M_IRIN | M_RUN, 16'h0, 16'h0, 5'h00};
  localparam logic [54:0] ZERO = 55'h0;

  wire [17:0] ctl = {HIin, LOin, PCin, MDRin, IRin, MARin, Yin, Zin, HIout, LOout,
                     Zhighout, Zlowout, PCout, MDRout, Read, IncPC, instr_done, run};
  wire [54:0] obs = {ctl, Rin, Rout, ALU_Control};

  // Datapath stand-in: register file, Y, Z, HI/LO and IR loaded from next_instr.
  logic [31:0] next_instr = 32'h0;
  logic [31:0] regs [16];
  logic        preloaded = 1'b0;
  logic [31:0] y_r = 32'h0, z_lo = 32'h0, z_hi = 32'h0, hi_r = 32'h0, lo_r = 32'h0;
  logic [31:0] bus_s;

  function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [5:0] sh;
    sh = {1'b0, b[4:0]};
    case (op)
      5'h00:   alu_model = {32'h0, a + b};
      5'h07:   alu_model = {32'h0, (a >> sh) | (a << (6'd32 - sh))};
      5'h0F:   alu_model = {32'h0, a} * {32'h0, b};
      5'h11:   alu_model = {32'h0, 32'h0 - b};
      default: alu_model = 64'h0;
    endcase
  endfunction

  always_comb begin
    bus_s = 32'h0;
    for (int i = 0; i < 16; i++) if (Rout[i]) bus_s = regs[i];
    if (Zlowout)  bus_s = z_lo;
    if (Zhighout) bus_s = z_hi;
  end

  always @(posedge clock) begin
    if (!preloaded) begin
      for (int i = 0; i < 16; i++) regs[i] <= {8{4'(i)}};
      regs[0] <= 32'h0000_0034;
      regs[1] <= 32'h0000_0010;
      regs[2] <= 32'h0001_0001;
      regs[3] <= 32'h0003_0000;
      regs[4] <= 32'h0000_0045;
      preloaded <= 1'b1;
    end else begin
      if (Yin) y_r <= bus_s;
      if (Zin) {z_hi, z_lo} <= alu_model(ALU_Control, y_r, bus_s);
      for (int i = 0; i < 16; i++) if (Rin[i]) regs[i] <= bus_s;
      if (LOin) lo_r <= bus_s;
      if (HIin) hi_r <= bus_s;
      if (IRin) IR <= next_instr;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    next_instr = 32'h3B82_0000;
    #1;
    n_vec++;
    if (obs !== ZERO) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want %h", obs, ZERO);
    end
    #4 clear = 1'b0;
    tick();
    n_vec++;
    if (obs !== F_T0) begin
      n_err++;
      $display("FAIL reset_first_t0: got %h want %h", obs, F_T0);
    end
  endtask

  task automatic test_ror();
    logic [54:0] exp_v [6];
    next_instr = 32'h3B82_0000;
    exp_v[0] = F_T1;
    exp_v[1] = F_T2;
    exp_v[2] = {M_YIN | M_RUN, 16'h0000, 16'h0001, 5'h00};
    exp_v[3] = {M_ZIN | M_RUN, 16'h0000, 16'h0010, 5'h07};
    exp_v[4] = {M_ZLOUT | M_DONE | M_RUN, 16'h0080, 16'h0000, 5'h00};
    exp_v[5] = F_T0;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_vec++;
      if (obs !== exp_v[k]) begin
        n_err++;
        $display("FAIL ror step %0d: got %h want %h", k, obs, exp_v[k]);
      end
    end
    n_vec++;
    if (regs[7] !== 32'hA000_0001) begin
      n_err++;
      $display("FAIL ror_result R7: got %h want a0000001", regs[7]);
    end
  endtask

  task automatic test_mul();
    logic [54:0] exp_v [7];
    next_instr = 32'h7918_0000;
    exp_v[0] = F_T1;
    exp_v[1] = F_T2;
    exp_v[2] = {M_YIN | M_RUN, 16'h0000, 16'h0004, 5'h00};
    exp_v[3] = {M_ZIN | M_RUN, 16'h0000, 16'h0008, 5'h0F};
    exp_v[4] = {M_ZLOUT | M_LOIN | M_RUN, 16'h0000, 16'h0000, 5'h00};
    exp_v[5] = {M_ZHOUT | M_HIIN | M_DONE | M_RUN, 16'h0000, 16'h0000, 5'h00};
    exp_v[6] = F_T0;
    for (int k = 0; k < 7; k++) begin
      tick();
      n_vec++;
      if (obs !== exp_v[k]) begin
        n_err++;
        $display("FAIL mul step %0d: got %h want %h", k, obs, exp_v[k]);
      end
    end
    n_vec++;
    if ({hi_r, lo_r} !== 64'h0000_0003_0003_0000) begin
      n_err++;
      $display("FAIL mul_result HI:LO: got %h%h want 0000000300030000", hi_r, lo_r);
    end
  endtask

  task automatic test_stall_nop();
    logic [54:0] exp_v [7];
    logic        mr_v [7];
    logic        st_v [7];
    next_instr = 32'hD000_0000;
    exp_v[0] = F_T1;  exp_v[1] = F_T1;  exp_v[2] = F_T1;  exp_v[3] = F_T1;
    exp_v[4] = F_T2;
    exp_v[5] = {M_DONE | M_RUN, 16'h0000, 16'h0000, 5'h00};
    exp_v[6] = F_T0;
    mr_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    st_v = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 7; k++) begin
      mem_ready = mr_v[k];
      stop = st_v[k];
      tick();
      n_vec++;
      if (obs !== exp_v[k]) begin
        n_err++;
        $display("FAIL stall_nop step %0d: got %h want %h", k, obs, exp_v[k]);
      end
    end
    mem_ready = 1'b1;
    stop = 1'b0;
  endtask

  task automatic test_unary();
    logic [54:0] exp_v [5];
    next_instr = 32'h8C88_0000;
    exp_v[0] = F_T1;
    exp_v[1] = F_T2;
    exp_v[2] = {M_ZIN | M_RUN, 16'h0000, 16'h0002, 5'h11};
    exp_v[3] = {M_ZLOUT | M_DONE | M_RUN, 16'h0200, 16'h0000, 5'h00};
    exp_v[4] = F_T0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec++;
      if (obs !== exp_v[k]) begin
        n_err++;
        $display("FAIL neg step %0d: got %h want %h", k, obs, exp_v[k]);
      end
    end
    n_vec++;
    if (regs[9] !== 32'hFFFF_FFF0) begin
      n_err++;
      $display("FAIL neg_result R9: got %h want fffffff0", regs[9]);
    end
  endtask

  task automatic test_stop_halt();
    logic [54:0] exp_v [15];
    next_instr = 32'h0289_0000;
    exp_v[0] = F_T1;
    exp_v[1] = F_T2;
    exp_v[2] = {M_YIN | M_RUN, 16'h0000, 16'h0002, 5'h00};
    exp_v[3] = {M_ZIN | M_RUN, 16'h0000, 16'h0004, 5'h00};
    exp_v[4] = {M_ZLOUT | M_DONE | M_RUN, 16'h0020, 16'h0000, 5'h00};
    for (int k = 5; k < 15; k++) exp_v[k] = ZERO;
    for (int k = 0; k < 15; k++) begin
      if (k == 4) stop = 1'b1;
      if (k == 6) stop = 1'b0;
      tick();
      n_vec++;
      if (obs !== exp_v[k]) begin
        n_err++;
        $display("FAIL stop_halt step %0d: got %h want %h", k, obs, exp_v[k]);
      end
    end
    n_vec++;
    if (regs[5] !== 32'h0001_0011) begin
      n_err++;
      $display("FAIL add_result R5: got %h want 00010011", regs[5]);
    end
  endtask

  task automatic test_mid_reset();
    logic [54:0] exp_v [5];
    next_instr = 32'h0409_0000;
    clear = 1'b1;
    #1;
    n_vec++;
    if (obs !== ZERO) begin
      n_err++;
      $display("FAIL clear_from_halt: got %h want %h", obs, ZERO);
    end
    #3 clear = 1'b0;
    exp_v[0] = F_T0;
    exp_v[1] = F_T1;
    exp_v[2] = F_T2;
    exp_v[3] = {M_YIN | M_RUN, 16'h0000, 16'h0002, 5'h00};
    exp_v[4] = {M_ZIN | M_RUN, 16'h0000, 16'h0004, 5'h00};
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec++;
      if (obs !== exp_v[k]) begin
        n_err++;
        $display("FAIL mid_reset step %0d: got %h want %h", k, obs, exp_v[k]);
      end
    end
    clear = 1'b1;
    #1;
    n_vec++;
    if (obs !== ZERO) begin
      n_err++;
      $display("FAIL clear_async: got %h want %h", obs, ZERO);
    end
    tick();
    n_vec++;
    if (obs !== ZERO) begin
      n_err++;
      $display("FAIL clear_held: got %h want %h", obs, ZERO);
    end
    #4 clear = 1'b0;
    n_vec++;
    if (regs[8] !== 32'h8888_8888) begin
      n_err++;
      $display("FAIL mid_reset_no_write R8: got %h want 88888888", regs[8]);
    end
    tick();
    n_vec++;
    if (obs !== F_T0) begin
      n_err++;
      $display("FAIL mid_reset_restart: got %h want %h", obs, F_T0);
    end
  endtask

  task automatic test_halt_instr();
    logic [54:0] exp_v [14];
    next_instr = 32'hD800_0000;
    exp_v[0] = F_T1;
    exp_v[1] = F_T2;
    exp_v[2] = {M_DONE | M_RUN, 16'h0000, 16'h0000, 5'h00};
    for (int k = 3; k < 14; k++) exp_v[k] = ZERO;
    for (int k = 0; k < 14; k++) begin
      tick();
      n_vec++;
      if (obs !== exp_v[k]) begin
        n_err++;
        $display("FAIL halt_instr step %0d: got %h want %h", k, obs, exp_v[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ror();
    test_mul();
    test_stall_nop();
    test_unary();
    test_stop_halt();
    test_mid_reset();
    test_halt_instr();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
